// File: rtl/typing_pkg.sv
// Shared typing-game types and constants: slot record layout, screen geometry, speed and ASCII anchors.
package typing_pkg;
  localparam int ROWS          = 30;
  localparam int SLOTS         = 8;
  localparam logic [7:0] ASCII_UPPER_A = 8'd65;
  localparam logic [7:0] ASCII_LOWER_A = 8'd97;
  localparam int SPEED_PERIODS = 4;

  typedef struct packed {
    logic       active;
    logic [5:0] col;
    logic [4:0] row;
    logic [7:0] ascii;
    logic [2:0] period;
    logic [2:0] cnt;
  } slot_t;
endpackage

// File: rtl/falling_char_pool_if.sv
// Game-side bus of the falling character pool: LFSR samples, keystrokes, renderer read port and score outputs.
interface falling_char_pool_if #(parameter int SLOTS = 8);
  localparam int IW = $clog2(SLOTS);

  logic          en;
  logic          frame_tick;
  logic          rng_en;
  logic [7:0]    rnd_velocity;
  logic [5:0]    rnd_position;
  logic [7:0]    rnd_ascii;
  logic          key_valid;
  logic [7:0]    key_ascii;
  logic [IW-1:0] rd_slot;
  logic          rd_valid;
  logic [5:0]    rd_col;
  logic [4:0]    rd_row;
  logic [7:0]    rd_ascii;
  logic          hit;
  logic          miss;
  logic          typo;
  logic [15:0]   score;
  logic [7:0]    miss_count;

  modport master (
    output en, frame_tick, rnd_velocity, rnd_position, rnd_ascii, key_valid, key_ascii, rd_slot,
    input  rng_en, rd_valid, rd_col, rd_row, rd_ascii, hit, miss, typo, score, miss_count
  );
  modport slave (
    input  en, frame_tick, rnd_velocity, rnd_position, rnd_ascii, key_valid, key_ascii, rd_slot,
    output rng_en, rd_valid, rd_col, rd_row, rd_ascii, hit, miss, typo, score, miss_count
  );
endinterface

// File: rtl/slot_picker.sv
// Combinational slot selection: first free slot, and the keystroke winner (deepest row, then lowest index).
module slot_picker #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]      active_i,
  input  logic [N-1:0][4:0] row_i,
  input  logic [N-1:0][7:0] ascii_i,
  input  logic [7:0]        key_ascii_i,
  output logic [IW-1:0]     free_idx_o,
  output logic              free_found_o,
  output logic [IW-1:0]     win_idx_o,
  output logic              win_found_o
);
  logic [4:0] best_row;

  always_comb begin
    free_idx_o   = '0;
    free_found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!active_i[i]) begin
        free_idx_o   = IW'(i);
        free_found_o = 1'b1;
      end
    end

    // Strict '>' keeps the earliest index on equal rows.
    win_idx_o   = '0;
    win_found_o = 1'b0;
    best_row    = '0;
    for (int i = 0; i < N; i++) begin
      if (active_i[i] && ascii_i[i] == key_ascii_i && (!win_found_o || row_i[i] > best_row)) begin
        win_idx_o   = IW'(i);
        win_found_o = 1'b1;
        best_row    = row_i[i];
      end
    end
  end
endmodule

// File: rtl/falling_char_pool.sv
// Pool of falling characters: spawns from LFSR samples, drops them per frame, scores hits and misses.
module falling_char_pool #(
  parameter int SLOTS        = 8,
  parameter int ROWS         = 30,
  parameter int SPAWN_PERIOD = 45
) (
  input  logic               clk,
  input  logic               rst,
  falling_char_pool_if.slave bus
);
  import typing_pkg::*;

  localparam int IW  = $clog2(SLOTS);
  localparam int SPW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

  slot_t [SLOTS-1:0]       slot_q, slot_d;
  logic  [SPW-1:0]         spawn_cnt_q, spawn_cnt_d;
  logic                    rng_en_q;
  logic                    hit_q, hit_d, miss_q, miss_d, typo_q, typo_d;
  logic  [15:0]            score_q, score_d;
  logic  [7:0]             miss_count_q, miss_count_d;
  logic  [SLOTS-1:0]       act;
  logic  [SLOTS-1:0][4:0]  rows;
  logic  [SLOTS-1:0][7:0]  chars;
  logic  [IW-1:0]          free_idx, win_idx;
  logic                    free_found, win_found;
  logic                    spawn_now;
  logic  [4:0]             nmiss;
  logic  [8:0]             mc_sum;
  logic  [2:0]             new_period;
  logic                    unused_vel;

  assign unused_vel = ^bus.rnd_velocity[5:0];

  for (genvar g = 0; g < SLOTS; g++) begin : g_view
    assign act[g]   = slot_q[g].active;
    assign rows[g]  = slot_q[g].row;
    assign chars[g] = slot_q[g].ascii;
  end

  slot_picker #(.N(SLOTS), .IW(IW)) u_picker (
    .active_i     (act),
    .row_i        (rows),
    .ascii_i      (chars),
    .key_ascii_i  (bus.key_ascii),
    .free_idx_o   (free_idx),
    .free_found_o (free_found),
    .win_idx_o    (win_idx),
    .win_found_o  (win_found)
  );

  always_comb begin
    slot_d       = slot_q;
    spawn_cnt_d  = spawn_cnt_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    typo_d       = 1'b0;
    score_d      = score_q;
    miss_count_d = miss_count_q;
    nmiss        = '0;
    mc_sum       = '0;
    spawn_now    = 1'b0;
    new_period   = 3'(SPEED_PERIODS) - {1'b0, bus.rnd_velocity[7:6]};

    if (!bus.en) begin
      slot_d      = '0;
      spawn_cnt_d = '0;
    end else begin
      if (bus.frame_tick) begin
        if (spawn_cnt_q == SPW'(SPAWN_PERIOD - 1)) begin
          spawn_cnt_d = '0;
          spawn_now   = 1'b1;
        end else begin
          spawn_cnt_d = spawn_cnt_q + 1'b1;
        end
      end

      // A hit slot is removed instead of falling, so it can never also miss.
      for (int i = 0; i < SLOTS; i++) begin
        if (slot_q[i].active) begin
          if (bus.key_valid && win_found && win_idx == IW'(i)) begin
            slot_d[i] = '0;
          end else if (bus.frame_tick) begin
            if (slot_q[i].cnt == 3'd1) begin
              if (slot_q[i].row == 5'(ROWS - 1)) begin
                slot_d[i] = '0;
                nmiss     = nmiss + 5'd1;
              end else begin
                slot_d[i].row = slot_q[i].row + 5'd1;
                slot_d[i].cnt = slot_q[i].period;
              end
            end else begin
              slot_d[i].cnt = slot_q[i].cnt - 3'd1;
            end
          end
        end
      end

      if (spawn_now && free_found) begin
        slot_d[free_idx] = '{active: 1'b1, col: bus.rnd_position, row: 5'd0,
                             ascii: bus.rnd_ascii, period: new_period, cnt: new_period};
      end

      if (bus.key_valid) begin
        if (win_found) begin
          hit_d = 1'b1;
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        end else begin
          typo_d = 1'b1;
        end
      end

      miss_d       = (nmiss != 5'd0);
      mc_sum       = {1'b0, miss_count_q} + 9'(nmiss);
      miss_count_d = mc_sum[8] ? 8'hFF : mc_sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q       <= '0;
      spawn_cnt_q  <= '0;
      rng_en_q     <= 1'b0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      typo_q       <= 1'b0;
      score_q      <= '0;
      miss_count_q <= '0;
    end else begin
      slot_q       <= slot_d;
      spawn_cnt_q  <= spawn_cnt_d;
      rng_en_q     <= bus.en;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      typo_q       <= typo_d;
      score_q      <= score_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign bus.rng_en     = rng_en_q;
  assign bus.hit        = hit_q;
  assign bus.miss       = miss_q;
  assign bus.typo       = typo_q;
  assign bus.score      = score_q;
  assign bus.miss_count = miss_count_q;
  assign bus.rd_valid   = slot_q[bus.rd_slot].active;
  assign bus.rd_col     = slot_q[bus.rd_slot].col;
  assign bus.rd_row     = slot_q[bus.rd_slot].row;
  assign bus.rd_ascii   = slot_q[bus.rd_slot].ascii;
endmodule

// File: doc/falling_char_pool.md
# falling_char_pool

Downstream consumer of the LFSR random stage in the typing game. Holds a fixed pool of falling characters: it samples the LFSR's position, ASCII and velocity outputs to spawn a new character at the top row, moves each character down at its own speed on every frame tick, and removes it on a matching keystroke (hit) or when it leaves the bottom row (miss). It keeps the score and miss counts, and exposes a slot read port for the VGA text renderer.

## Interface
Parameters:
- SLOTS, 8: number of concurrent characters (power of 2, 2..16).
- ROWS, 30: screen text rows; row index runs 0..ROWS-1.
- SPAWN_PERIOD, 45: frame ticks between spawn attempts (>=1).

Ports:
- clk, in, 1: single system clock.
- rst, in, 1: synchronous, active-high reset.
- en, in, 1: game running.
- frame_tick, in, 1: one-cycle pulse per video frame.
- rng_en, out, 1: drives the LFSR en input.
- rnd_velocity, in, 8: LFSR velocity output.
- rnd_position, in, 6: LFSR column output, 1..52.
- rnd_ascii, in, 8: LFSR character output.
- key_valid, in, 1: one-cycle pulse carrying a decoded keystroke.
- key_ascii, in, 8: ASCII code of the keystroke.
- rd_slot, in, $clog2(SLOTS): display read index.
- rd_valid, out, 1: the slot is active.
- rd_col, out, 6: column of the slot.
- rd_row, out, 5: row of the slot.
- rd_ascii, out, 8: character in the slot.
- hit, out, 1: one-cycle pulse when a keystroke removes a character.
- miss, out, 1: one-cycle pulse when a character falls off the bottom.
- typo, out, 1: one-cycle pulse when a keystroke matches no active character.
- score, out, 16: hit count, saturates at 16'hFFFF.
- miss_count, out, 8: miss count, saturates at 8'hFF.

## Operation
- Per-slot state: active, col[5:0], row[4:0], ascii[7:0], period[2:0], cnt[2:0].
- rng_en is a registered copy of en. It is 0 during rst, so the LFSR reseeds while the game is stopped.
- Spawn counter:
  - Increments on each frame_tick while en is 1.
  - When it reaches SPAWN_PERIOD-1 on a tick, it wraps to 0 and a spawn is attempted in that same cycle.
- Spawn:
  - Uses the lowest-index slot that was inactive at the start of the cycle.
  - Loads col=rnd_position, row=0, ascii=rnd_ascii, period = 4 - rnd_velocity[7:6] (range 1..4), cnt=period, active=1.
  - If no slot is free, the spawn is dropped and the counter still wraps.
- Fall, on frame_tick, for each active slot not hit this cycle:
  - If cnt==1: reload cnt=period and advance the row.
  - Otherwise: decrement cnt.
  - If the slot advances while row==ROWS-1, it is cleared and a miss is raised.
- Key match, on key_valid:
  - Candidates are active slots with ascii==key_ascii, evaluated on state at the start of the cycle.
  - Winner is the candidate with the largest row; ties go to the lowest index.
  - Winner is cleared and hit is raised. With no candidate, typo is raised.
- Multiple misses in one tick produce a single miss pulse; miss_count adds the number of slots that fell off, saturating.
- When en is 0: all slots are cleared, the spawn counter is cleared, key_valid and frame_tick are ignored, and score and miss_count hold.
- rst clears all slots, counters, score, miss_count and every pulse output.

## Timing
- Reset values: rng_en=0, hit=0, miss=0, typo=0, score=0, miss_count=0, all slots inactive, so rd_valid=0.
- Slot state, score and miss_count update on the clock edge that ends the event cycle.
- hit, miss and typo are registered and high for exactly the cycle after the event cycle.
- The read port is combinational from slot registers: the new slot state is visible one cycle after the event cycle.
- A slot freed in cycle N can be reused by a spawn in cycle N+1 or later, never in cycle N.
- key_valid and frame_tick in the same cycle: the hit slot neither advances nor misses; all other slots fall normally.
- rst mid-game takes priority over every event in that cycle.

## Structure
- Shared package typing_pkg holds:
  - ROWS, SLOTS, the ASCII range constants 65/97, and the speed-period constant 4.
  - typedef slot_t = {active, col, row, ascii, period, cnt}.
- Natural sub-module slot_picker (combinational):
  - Priority-encodes the first free slot.
  - Selects the match winner by largest row, then lowest index.
  - Outputs index plus found flag.
- Reused by any future multi-line variant.

## Test plan
- rst high 2 cycles -> all outputs 0, rd_valid=0 for every slot. Then en=1 -> rng_en=1 the next cycle.
- SPAWN_PERIOD=2, rnd_position=10, rnd_ascii=8'h61, rnd_velocity=8'hC0, two ticks -> slot 0 holds col=10, row=0, ascii=a, period=1. Each further tick advances row by 1.
- Fill all 8 slots, then one more spawn attempt -> no slot changes and no error. Clearing slot 3 leads to the next spawn landing in slot 3.
- Slots at rows 5 and 12, both 'a', key_ascii=8'h61 -> the row-12 slot is cleared, hit=1 for one cycle, score=1. Then key 'z' -> typo=1, score unchanged.
- Slot at row 29 with cnt=1, frame_tick and a matching key in the same cycle -> hit=1, miss=0, miss_count unchanged.
- score preloaded to 16'hFFFF, then a hit -> score stays FFFF. en dropped mid-game -> all slots cleared, score held.
